fft_frame_sched: RTL and testbench
==================================

// Module: fft_frame_sched
// PURPOSE
//  Frame scheduler for the tuner FFT path. It captures N samples into the FFT input buffer and
//  launches the FFT core, waiting for its completion. It then scans the magnitude RAM over bins
//  1..N/2-1 for the peak bin and presents the result to the display/pitch logic with a Done/Ack
//  handshake. It sits between the sample front end, the FFT core and the SSD/inspect logic.
// PARAMETERS
//  ADDR_W   8     log2(N); frame length N = 2**ADDR_W samples
//  DATA_W   12    sample width
//  MAG_W    16    magnitude width read back from magnitude RAM
//  TIMEOUT  4095  max cycles to wait for Fft_Done after Fft_Start (>=1)
// PORTS
//  Clk           in   1        system clock, all logic on rising edge
//  Reset         in   1        synchronous, active-high reset
//  Start         in   1        begin a frame; honoured only in IDLE
//  Ack           in   1        result consumed; honoured only in DONE
//  Continuous    in   1        sampled in DONE on Ack: 1 = start next frame, 0 = go IDLE
//  Sample_Valid  in   1        one sample on Sample_In this cycle
//  Sample_In     in   DATA_W   sample data
//  Buf_Wr_En     out  1        FFT input buffer write strobe (registered)
//  Buf_Wr_Addr   out  ADDR_W   write address
//  Buf_Wr_Data   out  DATA_W   write data
//  Fft_Start     out  1        one-cycle start pulse to FFT core
//  Fft_Done      in   1        FFT core completion (level or pulse)
//  Mag_Rd_Addr   out  ADDR_W   magnitude RAM read address; data returns 1 cycle later
//  Mag_Rd_Data   in   MAG_W    magnitude RAM read data
//  Peak_Bin      out  ADDR_W   bin index of the maximum magnitude
//  Peak_Mag      out  MAG_W    maximum magnitude
//  Ready         out  1        1 in IDLE
//  Done          out  1        1 in DONE; Peak_* stable while high
//  Error         out  1        FFT timeout on last frame; held until next Start or Reset
//  State_Out     out  3        state code for Inspect/SSD: IDLE=0 CAPTURE=1 FFT_RUN=2 SCAN=3 DRAIN=4 DONE=5
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except Ready=1; counters cleared. Reset mid-frame aborts
//   on the same edge, Fft_Start/Buf_Wr_En are low the following cycle, and no partial result is kept.
//  IDLE: Start=1 -> CAPTURE next cycle. Error and Peak_* clear on that edge; write count=0.
//  CAPTURE: Sample_Valid=1 on cycle t -> Buf_Wr_En=1 on t+1, Addr=count, Data=Sample_In@t.
//   Count increments per sample, wrapping to 0 after N-1. The edge that accepts sample N-1 enters
//   FFT_RUN. Sample_Valid outside CAPTURE is dropped; Buf_Wr_En never rises then.
//  FFT_RUN: Fft_Start=1 only on the first cycle in the state. Fft_Done is ignored on that cycle.
//   Fft_Done=1 on a later cycle -> SCAN next. Watchdog counts cycles in the state; at TIMEOUT
//   without Done -> Error=1, Peak_*=0, go DONE (skip scan).
//  SCAN: Mag_Rd_Addr = 1,2,..,N/2-1, one per cycle starting at SCAN entry. After addr N/2-1
//   is issued -> DRAIN. Each returned word is compared one cycle after its address; update
//   Peak_* only if strictly greater (ties keep the lower bin). Bin 0 (DC) and bins >= N/2 are
//   never read.
//  DRAIN: compare the last word -> DONE. SCAN entry to DONE is exactly N/2 cycles.
//   All-zero spectrum -> Peak_Bin=0, Peak_Mag=0.
//  DONE: Done=1, Peak_* and Error held. Ack=1 -> if Continuous then CAPTURE (Error clears, count=0)
//   else IDLE. Start in DONE is ignored. Ack and Start outside their states are ignored.
//  Mag_Rd_Addr is 0 outside SCAN. Only one state transition occurs per cycle, and Reset beats all inputs.
// TESTING (ADDR_W=4, N=16, TIMEOUT=20 unless stated)
//  1 Reset held 5 cycles, then Start pulse -> Ready 1->0, State_Out=1, Buf_Wr_En=0 until first Sample_Valid.
//  2 16 back-to-back samples 0..15 -> writes addr 0..15 data 0..15; a single Fft_Start pulse the cycle after last write edge.
//  3 Fft_Done after 7 cycles, mag RAM bin k = (k==5)?900:(k==3)?900:10 -> Peak_Bin=3, Peak_Mag=900, Done 8 cycles after SCAN entry.
//  4 Fft_Done never asserted -> Error=1, Done=1 after 20 cycles in FFT_RUN, Peak_*=0; next Start clears Error.
//  5 Continuous=1, Ack in DONE -> CAPTURE, second frame result replaces first; Continuous=0 -> IDLE, Ready=1.
//  6 Reset asserted mid-CAPTURE (after 9 samples) and mid-SCAN -> IDLE next cycle, all outputs at reset values; Start/Ack/Sample_Valid in wrong states cause no change.

Source files
------------

// File: rtl/fft_frame_sched.sv
// Tuner FFT frame scheduler: captures N samples, launches the FFT core, then scans
// magnitude bins 1..N/2-1 for the peak and holds the result until it is acknowledged.
module fft_frame_sched #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 12,
  parameter int MAG_W   = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic              continuous,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [ADDR_W-1:0] mag_rd_addr,
  input  logic [MAG_W-1:0]  mag_rd_data,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [MAG_W-1:0]  peak_mag,
  output logic              ready,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_out
);

  localparam int N    = 1 << ADDR_W;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_SAMPLE = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_BIN    = ADDR_W'(N / 2 - 1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FFT_RUN = 3'd2,
    S_SCAN    = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              timeout;
  logic              enter_capture;
  logic [ADDR_W-1:0] wr_count;
  logic [WD_W-1:0]   wd_count;
  logic [ADDR_W-1:0] scan_addr;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_bin;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // wd_count is zero only on the first FFT_RUN cycle, which is where a stale Done is ignored
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (sample_valid && (wr_count == LAST_SAMPLE)) begin
          next_state = S_FFT_RUN;
        end
      end
      S_FFT_RUN: begin
        if (fft_done && (wd_count != '0)) begin
          next_state = S_SCAN;
        end else if (wd_count == WD_LAST) begin
          next_state = S_DONE;
          timeout    = 1'b1;
        end
      end
      S_SCAN: begin
        if (scan_addr == LAST_BIN) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        next_state = S_DONE;
      end
      S_DONE: begin
        if (ack) begin
          next_state = continuous ? S_CAPTURE : S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign enter_capture = (next_state == S_CAPTURE) && (state != S_CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      fft_start   <= 1'b0;
      wr_count    <= '0;
      wd_count    <= '0;
      scan_addr   <= ADDR_W'(1);
      cmp_valid   <= 1'b0;
      cmp_bin     <= '0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      error       <= 1'b0;
    end else begin
      buf_wr_en <= 1'b0;
      fft_start <= (state != S_FFT_RUN) && (next_state == S_FFT_RUN);
      cmp_valid <= (state == S_SCAN);
      cmp_bin   <= scan_addr;

      if ((state == S_CAPTURE) && sample_valid) begin
        buf_wr_en   <= 1'b1;
        buf_wr_addr <= wr_count;
        buf_wr_data <= sample_in;
        wr_count    <= wr_count + 1'b1;
      end

      if (enter_capture) begin
        wr_count <= '0;
        error    <= 1'b0;
        peak_bin <= '0;
        peak_mag <= '0;
      end

      if (state == S_FFT_RUN) begin
        wd_count <= wd_count + 1'b1;
      end else begin
        wd_count <= '0;
      end

      if (timeout) begin
        error    <= 1'b1;
        peak_bin <= '0;
        peak_mag <= '0;
      end

      if (state == S_SCAN) begin
        scan_addr <= scan_addr + 1'b1;
      end else begin
        scan_addr <= ADDR_W'(1);
      end

      // RAM data lags its address by one cycle; strict compare keeps the lowest tied bin
      if (cmp_valid && (mag_rd_data > peak_mag)) begin
        peak_bin <= cmp_bin;
        peak_mag <= mag_rd_data;
      end
    end
  end

  assign mag_rd_addr = (state == S_SCAN) ? scan_addr : '0;
  assign ready       = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign state_out   = state;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboard bench for fft_frame_sched (N=16, TIMEOUT=20): buffer writes and frame
// results are queued as expected when stimulus is issued and checked by a monitor.
module tb_fft_frame_sched;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 12;
  localparam int MAG_W   = 16;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              ack;
  logic              continuous;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;
  logic              fft_start;
  logic              fft_done;
  logic [ADDR_W-1:0] mag_rd_addr;
  logic [MAG_W-1:0]  mag_rd_data;
  logic [ADDR_W-1:0] peak_bin;
  logic [MAG_W-1:0]  peak_mag;
  logic              ready;
  logic              done;
  logic              error;
  logic [2:0]        state_out;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] bin;
    logic [MAG_W-1:0]  mag;
    logic              err;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  logic [MAG_W-1:0] mag_mem [16];

  int   tests = 0;
  int   fails = 0;
  int   fft_start_cnt = 0;
  logic done_prev = 1'b0;
  wr_t  mon_w;
  res_t mon_r;

  fft_frame_sched #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MAG_W  (MAG_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .continuous  (continuous),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .mag_rd_addr (mag_rd_addr),
    .mag_rd_data (mag_rd_data),
    .peak_bin    (peak_bin),
    .peak_mag    (peak_mag),
    .ready       (ready),
    .done        (done),
    .error       (error),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  // Magnitude RAM model with one cycle read latency
  always @(posedge clk) begin
    mag_rd_data <= mag_mem[mag_rd_addr];
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check_output("unexpected write", 32'(buf_wr_addr), 32'hFFFF_FFFF);
      end else begin
        mon_w = wr_q.pop_front();
        check_output("write addr", 32'(buf_wr_addr), 32'(mon_w.addr));
        check_output("write data", 32'(buf_wr_data), 32'(mon_w.data));
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (res_q.size() == 0) begin
        check_output("unexpected result", 32'(peak_mag), 32'hFFFF_FFFF);
      end else begin
        mon_r = res_q.pop_front();
        check_output("peak bin", 32'(peak_bin), 32'(mon_r.bin));
        check_output("peak mag", 32'(peak_mag), 32'(mon_r.mag));
        check_output("error flag", 32'(error), 32'(mon_r.err));
      end
    end
    if (state_out !== 3'd3 && mag_rd_addr !== '0) begin
      check_output("mag addr outside scan", 32'(mag_rd_addr), 0);
    end
    if (fft_start === 1'b1) begin
      fft_start_cnt++;
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mag(input int b1, input int v1, input int b2, input int v2,
                         input int other);
    for (int k = 0; k < 16; k++) begin
      mag_mem[k] = (k == b1) ? MAG_W'(v1) : (k == b2) ? MAG_W'(v2) : MAG_W'(other);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input int count, input int base);
    wr_t w;
    for (int i = 0; i < count; i++) begin
      w.addr = ADDR_W'(i);
      w.data = DATA_W'(base + i);
      wr_q.push_back(w);
      sample_valid = 1'b1;
      sample_in    = DATA_W'(base + i);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  // Called on the first FFT_RUN cycle; Done is pulsed on the delay-th cycle in the state
  task automatic run_fft(input int delay);
    for (int c = 1; c < delay; c++) begin
      tick();
      if (c == 1) check_output("fft_start one pulse", 32'(fft_start), 0);
    end
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int bound);
    int n = 0;
    while (state_out !== exp && n < bound) begin
      tick();
      n++;
    end
    check_output("wait state", 32'(state_out), 32'(exp));
  endtask

  task automatic check_scan(input int exp_bin, input int exp_mag);
    res_t r;
    r.bin = ADDR_W'(exp_bin);
    r.mag = MAG_W'(exp_mag);
    r.err = 1'b0;
    res_q.push_back(r);
    wait_state(3'd3, 30);
    for (int i = 1; i <= 7; i++) begin
      check_output("scan addr", 32'(mag_rd_addr), 32'(i));
      tick();
    end
    check_output("drain state", 32'(state_out), 4);
    check_output("drain addr", 32'(mag_rd_addr), 0);
    tick();
    check_output("done after N/2", 32'(done), 1);
    check_output("done state", 32'(state_out), 5);
    tick();
    tick();
    check_output("done held", 32'(done), 1);
    check_output("peak bin held", 32'(peak_bin), 32'(exp_bin));
    check_output("peak mag held", 32'(peak_mag), 32'(exp_mag));
  endtask

  task automatic ack_done(input logic cont);
    continuous = cont;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    continuous = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    res_t r;
    reset = 1'b1;
    start = 1'b0;
    ack = 1'b0;
    continuous = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    fft_done = 1'b0;
    set_mag(3, 900, 5, 900, 10);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    check_output("reset ready", 32'(ready), 1);
    check_output("reset state", 32'(state_out), 0);
    check_output("reset done", 32'(done), 0);
    check_output("reset error", 32'(error), 0);
    check_output("reset wr_en", 32'(buf_wr_en), 0);
    check_output("reset fft_start", 32'(fft_start), 0);
    check_output("reset mag addr", 32'(mag_rd_addr), 0);
    check_output("reset peak bin", 32'(peak_bin), 0);
    check_output("reset peak mag", 32'(peak_mag), 0);

    // Inputs outside their states do nothing in IDLE
    ack = 1'b1;
    sample_valid = 1'b1;
    continuous = 1'b1;
    repeat (3) tick();
    check_output("idle ignores ack/sample", 32'(state_out), 0);
    ack = 1'b0;
    sample_valid = 1'b0;
    continuous = 1'b0;

    // Start, then a full frame with a tie between bins 3 and 5
    pulse_start();
    check_output("start ready low", 32'(ready), 0);
    check_output("start capture", 32'(state_out), 1);
    check_output("no write before sample", 32'(buf_wr_en), 0);
    tick();
    check_output("no write idle capture", 32'(buf_wr_en), 0);
    apply_stimulus(16, 0);
    check_output("fft_start pulse", 32'(fft_start), 1);
    check_output("fft_run state", 32'(state_out), 2);
    run_fft(7);
    check_scan(3, 900);
    ack_done(1'b0);
    check_output("back to idle", 32'(state_out), 0);
    check_output("idle ready", 32'(ready), 1);

    // FFT timeout; samples during FFT_RUN must be dropped
    pulse_start();
    apply_stimulus(16, 16);
    r.bin = '0;
    r.mag = '0;
    r.err = 1'b1;
    res_q.push_back(r);
    sample_valid = 1'b1;
    sample_in = 12'hABC;
    repeat (19) tick();
    check_output("still fft_run", 32'(state_out), 2);
    check_output("no early done", 32'(done), 0);
    tick();
    sample_valid = 1'b0;
    check_output("timeout done", 32'(done), 1);
    check_output("timeout error", 32'(error), 1);
    check_output("timeout peak mag", 32'(peak_mag), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("start ignored in done", 32'(state_out), 5);
    ack_done(1'b0);
    check_output("error held in idle", 32'(error), 1);
    pulse_start();
    check_output("start clears error", 32'(error), 0);

    // Continuous frames: each result replaces the previous one
    set_mag(6, 500, 6, 500, 20);
    apply_stimulus(16, 100);
    run_fft(3);
    check_scan(6, 500);
    ack_done(1'b1);
    check_output("continuous capture", 32'(state_out), 1);
    check_output("continuous done low", 32'(done), 0);
    check_output("continuous peak clear", 32'(peak_mag), 0);

    set_mag(2, 77, 7, 78, 0);
    apply_stimulus(16, 200);
    fft_done = 1'b1;
    tick();
    check_output("done ignored first cycle", 32'(state_out), 2);
    tick();
    fft_done = 1'b0;
    check_scan(7, 78);
    ack_done(1'b1);

    set_mag(0, 0, 0, 0, 0);
    apply_stimulus(16, 300);
    run_fft(5);
    check_scan(0, 0);
    ack_done(1'b0);
    check_output("final idle", 32'(state_out), 0);
    check_output("final ready", 32'(ready), 1);

    // Reset mid-CAPTURE after 9 samples, with a sample pending on the reset edge
    pulse_start();
    apply_stimulus(9, 50);
    reset = 1'b1;
    sample_valid = 1'b1;
    tick();
    reset = 1'b0;
    sample_valid = 1'b0;
    check_output("cap reset state", 32'(state_out), 0);
    check_output("cap reset ready", 32'(ready), 1);
    check_output("cap reset wr_en", 32'(buf_wr_en), 0);
    tick();
    check_output("cap reset no write", 32'(buf_wr_en), 0);

    // Reset mid-SCAN after the peak has started updating
    set_mag(0, 0, 0, 0, 300);
    pulse_start();
    apply_stimulus(16, 400);
    run_fft(4);
    wait_state(3'd3, 30);
    tick();
    tick();
    check_output("scan peak updating", 32'(peak_mag), 300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("scan reset state", 32'(state_out), 0);
    check_output("scan reset mag addr", 32'(mag_rd_addr), 0);
    check_output("scan reset peak mag", 32'(peak_mag), 0);
    check_output("scan reset peak bin", 32'(peak_bin), 0);
    check_output("scan reset done", 32'(done), 0);
    check_output("scan reset fft_start", 32'(fft_start), 0);

    repeat (3) tick();
    check_output("writes drained", wr_q.size(), 0);
    check_output("results drained", res_q.size(), 0);
    check_output("fft_start count", fft_start_cnt, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
